// File: rtl/cb_read_seq.sv
// ============================================================================
// Module   : cb_read_seq
// Brief    : Walks a circular buffer of 72-bit words backwards from the newest
//            word and unpacks each word into four 18-bit samples.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cb_read_seq #(
    parameter int RD_LAT = 3
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enxk,
    input  logic [11:0] wbase,
    input  logic [11:0] nwords,
    output logic [11:0] addrout,
    input  logic [71:0] rdin,
    output logic [17:0] xout,
    output logic        xvalid,
    output logic        xfirst,
    output logic        xlast,
    output logic        busy,
    output logic        overrun
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t       r_state;
    state_t       w_next;

    logic [11:0]  r_addr;
    logic [12:0]  r_left;
    logic [1:0]   r_div;
    logic [RD_LAT:0] r_pv;
    logic [RD_LAT:0] r_pf;
    logic [RD_LAT:0] r_pl;
    logic [53:0]  r_rest;
    logic [17:0]  r_xout;
    logic         r_xvalid;
    logic         r_xfirst;
    logic         r_xlast;
    logic         r_xlast_d;
    logic [1:0]   r_lane;
    logic         r_lastw;
    logic         r_overrun;

    logic         w_accept;
    logic         w_step;
    logic [12:0]  w_nwords13;
    logic [1:0]   w_nlane;
    logic [17:0]  w_lane_data;

    assign w_accept   = enxk && (r_state == S_IDLE);
    assign w_step     = (r_state == S_ISSUE) && (r_left != 13'd0) && (r_div == 2'd3);
    assign w_nwords13 = (nwords == 12'd0) ? 13'd4096 : {1'b0, nwords};
    assign w_nlane    = r_lane + 2'd1;

    always_comb begin
        w_lane_data = r_rest[17:0];
        case (w_nlane)
            2'd1:    w_lane_data = r_rest[53:36];
            2'd2:    w_lane_data = r_rest[35:18];
            default: w_lane_data = r_rest[17:0];
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // DRAIN exits one cycle after xlast so busy covers the cycle following the last sample
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next = S_ISSUE;
            S_ISSUE: if (r_left == 13'd0) w_next = S_DRAIN;
            S_DRAIN: if (r_xlast_d) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_addr    <= 12'd0;
            r_left    <= 13'd0;
            r_div     <= 2'd0;
            r_pv      <= '0;
            r_pf      <= '0;
            r_pl      <= '0;
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= enxk && (r_state != S_IDLE);
            // Bit 0 marks the cycle an address is on the bus; bit RD_LAT marks its data on rdin
            r_pv <= {r_pv[RD_LAT-1:0], w_accept || w_step};
            r_pf <= {r_pf[RD_LAT-1:0], w_accept};
            r_pl <= {r_pl[RD_LAT-1:0], (w_accept && (w_nwords13 == 13'd1)) ||
                                       (w_step && (r_left == 13'd1))};
            if (w_accept) begin
                r_addr <= wbase;
                r_left <= w_nwords13 - 13'd1;
                r_div  <= 2'd0;
            end else begin
                if (r_state == S_ISSUE) begin
                    r_div <= r_div + 2'd1;
                end
                if (w_step) begin
                    r_addr <= r_addr - 12'd1;
                    r_left <= r_left - 13'd1;
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_rest    <= '0;
            r_xout    <= 18'd0;
            r_xvalid  <= 1'b0;
            r_xfirst  <= 1'b0;
            r_xlast   <= 1'b0;
            r_xlast_d <= 1'b0;
            r_lane    <= 2'd0;
            r_lastw   <= 1'b0;
        end else begin
            r_xlast_d <= r_xlast;
            if (r_pv[RD_LAT]) begin
                r_rest   <= rdin[53:0];
                r_xout   <= rdin[71:54];
                r_xvalid <= 1'b1;
                r_xfirst <= r_pf[RD_LAT];
                r_xlast  <= 1'b0;
                r_lastw  <= r_pl[RD_LAT];
                r_lane   <= 2'd0;
            end else if (r_xvalid && (r_lane != 2'd3)) begin
                r_lane   <= w_nlane;
                r_xout   <= w_lane_data;
                r_xfirst <= 1'b0;
                r_xlast  <= r_lastw && (w_nlane == 2'd3);
            end else begin
                r_xvalid <= 1'b0;
                r_xfirst <= 1'b0;
                r_xlast  <= 1'b0;
            end
        end
    end

    assign addrout = r_addr;
    assign xout    = r_xout;
    assign xvalid  = r_xvalid;
    assign xfirst  = r_xfirst;
    assign xlast   = r_xlast;
    assign busy    = (r_state != S_IDLE);
    assign overrun = r_overrun;

endmodule

`default_nettype wire

// File: tb/tb_cb_read_seq.sv
// ============================================================================
// Module   : tb_cb_read_seq
// Brief    : Scoreboard bench for cb_read_seq with a latency-exact RAM model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cb_read_seq;

    localparam int RD_LAT = 3;

    logic        clock;
    logic        reset;
    logic        enxk;
    logic [11:0] wbase;
    logic [11:0] nwords;
    logic [11:0] addrout;
    logic [71:0] rdin;
    logic [17:0] xout;
    logic        xvalid;
    logic        xfirst;
    logic        xlast;
    logic        busy;
    logic        overrun;

    cb_read_seq #(.RD_LAT(RD_LAT)) dut (
        .clock   (clock),
        .reset   (reset),
        .enxk    (enxk),
        .wbase   (wbase),
        .nwords  (nwords),
        .addrout (addrout),
        .rdin    (rdin),
        .xout    (xout),
        .xvalid  (xvalid),
        .xfirst  (xfirst),
        .xlast   (xlast),
        .busy    (busy),
        .overrun (overrun)
    );

    typedef struct {
        int          cyc;
        logic [17:0] x;
        bit          f;
        bit          l;
    } exp_t;

    exp_t        q[$];
    int          cyc = 0;
    int          n_chk = 0;
    int          n_fail = 0;
    bit          s_valid = 0;
    int          s_start = 0;
    int          s_n = 0;
    logic [11:0] s_base = 12'd0;
    int          ovr_cyc = -100;
    logic [17:0] last_x = 18'd0;

    initial clock = 1'b0;
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [17:0] lane_of(input logic [11:0] a, input int k);
        return {a, 2'(k), 4'(k * 3 + 1)};
    endfunction

    function automatic logic [71:0] word_of(input logic [11:0] a);
        return {lane_of(a, 0), lane_of(a, 1), lane_of(a, 2), lane_of(a, 3)};
    endfunction

    task automatic chk(input bit ok, input string name, input longint act, input longint req);
        n_chk++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h cycle=%0d", name, act, req, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // RAM model: real data only on the exact cycle RD_LAT after each issue, junk otherwise
    initial begin
        rdin = 72'd0;
        forever begin
            @(posedge clock);
            #2;
            begin
                int k;
                k = cyc - s_start - 1 - RD_LAT;
                if (s_valid && k >= 0 && (k % 4) == 0 && (k / 4) < s_n)
                    rdin = word_of(s_base - 12'(k / 4));
                else
                    rdin = 72'({$urandom, $urandom, $urandom});
            end
        end
    end

    initial begin
        forever begin
            @(negedge clock);
            if (reset) begin
                last_x = 18'd0;
            end else begin
                if (xvalid) begin
                    if (q.size() == 0) begin
                        chk(1'b0, "unexpected_xvalid", 1, 0);
                    end else begin
                        exp_t e;
                        e = q.pop_front();
                        chk(cyc == e.cyc, "xvalid_cycle", cyc, e.cyc);
                        chk({xout, xfirst, xlast} == {e.x, e.f, e.l}, "sample",
                            {xout, xfirst, xlast}, {e.x, e.f, e.l});
                    end
                    last_x = xout;
                end else begin
                    chk({xout, xfirst, xlast} == {last_x, 2'b00}, "idle_outputs",
                        {xout, xfirst, xlast}, {last_x, 2'b00});
                end
                if (q.size() > 0 && q[0].cyc < cyc) begin
                    chk(1'b0, "missed_sample", cyc, q[0].cyc);
                    void'(q.pop_front());
                end
                begin
                    bit eb;
                    eb = s_valid && cyc >= s_start + 1 && cyc <= s_start + 4 * s_n + RD_LAT + 2;
                    chk(busy == eb, "busy", busy, eb);
                end
                chk(overrun == (cyc == ovr_cyc + 1), "overrun", overrun, cyc == ovr_cyc + 1);
                if (s_valid && cyc >= s_start + 1 && cyc <= s_start + 4 * s_n) begin
                    logic [11:0] ea;
                    ea = s_base - 12'((cyc - s_start - 1) / 4);
                    chk(addrout == ea, "addrout", addrout, ea);
                end
            end
        end
    end

    task automatic start_sweep(input logic [11:0] base, input logic [11:0] n);
        enxk    = 1'b1;
        wbase   = base;
        nwords  = n;
        s_start = cyc;
        s_base  = base;
        s_n     = (n == 12'd0) ? 4096 : int'(n);
        s_valid = 1'b1;
        for (int j = 0; j < s_n; j++) begin
            for (int k = 0; k < 4; k++) begin
                exp_t e;
                e.cyc = s_start + 1 + 4 * j + RD_LAT + 1 + k;
                e.x   = lane_of(base - 12'(j), k);
                e.f   = (j == 0) && (k == 0);
                e.l   = (j == s_n - 1) && (k == 3);
                q.push_back(e);
            end
        end
        tick(1);
        enxk  = 1'b0;
        wbase = 12'($urandom);
    endtask

    // Returns in the first cycle busy is low again
    task automatic wait_end();
        int stop;
        stop = s_start + 4 * s_n + RD_LAT + 3;
        while (cyc < stop) tick(1);
        chk(q.size() == 0, "queue_drained", q.size(), 0);
    endtask

    task automatic chk_zero(input string tag);
        chk(addrout == 12'd0, {tag, "_addrout"}, addrout, 0);
        chk(xout == 18'd0, {tag, "_xout"}, xout, 0);
        chk(xvalid == 1'b0, {tag, "_xvalid"}, xvalid, 0);
        chk(xfirst == 1'b0, {tag, "_xfirst"}, xfirst, 0);
        chk(xlast == 1'b0, {tag, "_xlast"}, xlast, 0);
        chk(busy == 1'b0, {tag, "_busy"}, busy, 0);
        chk(overrun == 1'b0, {tag, "_overrun"}, overrun, 0);
    endtask

    initial begin
        reset  = 1'b1;
        enxk   = 1'b0;
        wbase  = 12'd0;
        nwords = 12'd0;
        tick(3);
        chk_zero("reset");
        reset = 1'b0;
        tick(2);

        start_sweep(12'h010, 12'd2);
        wait_end();
        // Accepted in the very cycle busy falls, and wraps through 0
        start_sweep(12'h001, 12'd3);
        wait_end();
        tick(3);

        start_sweep(12'h123, 12'd2);
        tick(3);
        enxk    = 1'b1;
        wbase   = 12'h777;
        nwords  = 12'd5;
        ovr_cyc = cyc;
        tick(1);
        enxk = 1'b0;
        wait_end();

        start_sweep(12'h7FF, 12'd1);
        wait_end();
        tick(2);

        start_sweep(12'h400, 12'd4);
        tick(5);
        #2;
        reset = 1'b1;
        #1;
        chk_zero("midreset");
        q.delete();
        s_valid = 1'b0;
        tick(2);
        reset = 1'b0;
        tick(20);

        start_sweep(12'h005, 12'd0);
        wait_end();
        tick(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
